hypot_unit_param: RTL and testbench

//  Parametrised multi-mode magnitude unit: W-bit operands, result selected by mode_i:

---
 rtl/hypot_unit_param.sv | 179 +++++++++++++++++
 tb/tb_hypot_unit_param.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hypot_unit_param.sv
// Multi-mode magnitude unit: hypot, sum of squares, integer sqrt or product of two
// W-bit operands, built on one shared shift-add multiplier and a restoring square root.
module hypot_unit_param #(
  parameter int W = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [W-1:0]   a_bi,
  input  logic [W-1:0]   b_bi,
  input  logic [1:0]     mode_i,
  input  logic           start_i,
  output logic [2*W:0]   y_bo,
  output logic           busy_o,
  output logic           done_o
);

  localparam int CW = $clog2(W + 2);
  localparam int RW = 2 * W + 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MUL_A = 3'd1;
  localparam logic [2:0] ST_MUL_B = 3'd2;
  localparam logic [2:0] ST_SUM   = 3'd3;
  localparam logic [2:0] ST_SQRT  = 3'd4;

  localparam logic [1:0] MODE_HYPOT = 2'd0;
  localparam logic [1:0] MODE_SUMSQ = 2'd1;
  localparam logic [1:0] MODE_SQRT  = 2'd2;
  localparam logic [1:0] MODE_MUL   = 2'd3;

  logic [2:0]     state_reg;
  logic [CW-1:0]  cnt_reg;
  logic [1:0]     mode_reg;
  logic [W-1:0]   b_reg;
  logic [2*W-1:0] mcand_reg;
  logic [W-1:0]   mplier_reg;
  logic [2*W-1:0] acc_reg;
  logic [2*W-1:0] asq_reg;
  logic [2*W-1:0] bsq_reg;
  logic [RW-1:0]  rad_reg;
  logic [W+1:0]   rem_reg;
  logic [W:0]     root_reg;

  logic [2*W-1:0] prod_next;
  logic [2*W:0]   sum_next;
  logic [W+3:0]   rem_shift;
  logic [W+3:0]   trial;
  logic [W+3:0]   rem_diff;
  logic           sq_fit;
  logic [W+1:0]   rem_next;
  logic [W:0]     root_next;
  logic           last_mul;
  logic           last_sqrt;

  // The final iteration's result is taken combinationally so the writing edge
  // coincides with the last iteration edge.
  assign prod_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign sum_next  = {1'b0, asq_reg} + {1'b0, bsq_reg};

  // One restoring step: bring down two radicand bits, try subtracting 4*root+1.
  assign rem_shift = {rem_reg, rad_reg[RW-1 -: 2]};
  assign trial     = {1'b0, root_reg, 2'b01};
  assign sq_fit    = (rem_shift >= trial);
  assign rem_diff  = sq_fit ? (rem_shift - trial) : rem_shift;
  assign rem_next  = rem_diff[W+1:0];
  assign root_next = {root_reg[W-1:0], sq_fit};

  assign last_mul  = (cnt_reg == CW'(W - 1));
  assign last_sqrt = (cnt_reg == CW'(W));

  assign busy_o = (state_reg != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      mode_reg   <= '0;
      b_reg      <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      asq_reg    <= '0;
      bsq_reg    <= '0;
      rad_reg    <= '0;
      rem_reg    <= '0;
      root_reg   <= '0;
      y_bo       <= '0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            mode_reg <= mode_i;
            b_reg    <= b_bi;
            cnt_reg  <= '0;
            if (mode_i == MODE_SQRT) begin
              rad_reg   <= {{(W + 2){1'b0}}, a_bi};
              rem_reg   <= '0;
              root_reg  <= '0;
              state_reg <= ST_SQRT;
            end else begin
              mcand_reg  <= {{W{1'b0}}, a_bi};
              mplier_reg <= (mode_i == MODE_MUL) ? b_bi : a_bi;
              acc_reg    <= '0;
              state_reg  <= ST_MUL_A;
            end
          end
        end

        ST_MUL_A: begin
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          acc_reg    <= prod_next;
          cnt_reg    <= cnt_reg + CW'(1);
          if (last_mul) begin
            cnt_reg <= '0;
            if (mode_reg == MODE_MUL) begin
              y_bo      <= {1'b0, prod_next};
              done_o    <= 1'b1;
              state_reg <= ST_IDLE;
            end else begin
              asq_reg    <= prod_next;
              mcand_reg  <= {{W{1'b0}}, b_reg};
              mplier_reg <= b_reg;
              acc_reg    <= '0;
              state_reg  <= ST_MUL_B;
            end
          end
        end

        ST_MUL_B: begin
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          acc_reg    <= prod_next;
          cnt_reg    <= cnt_reg + CW'(1);
          if (last_mul) begin
            cnt_reg   <= '0;
            bsq_reg   <= prod_next;
            state_reg <= ST_SUM;
          end
        end

        ST_SUM: begin
          cnt_reg <= '0;
          if (mode_reg == MODE_SUMSQ) begin
            y_bo      <= sum_next;
            done_o    <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            rad_reg   <= {1'b0, sum_next};
            rem_reg   <= '0;
            root_reg  <= '0;
            state_reg <= ST_SQRT;
          end
        end

        ST_SQRT: begin
          rad_reg  <= rad_reg << 2;
          rem_reg  <= rem_next;
          root_reg <= root_next;
          cnt_reg  <= cnt_reg + CW'(1);
          if (last_sqrt) begin
            cnt_reg   <= '0;
            y_bo      <= {{W{1'b0}}, root_next};
            done_o    <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          cnt_reg   <= '0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hypot_unit_param.sv
// Bench for hypot_unit_param (W=8): directed cases plus random operations checked
// against an arithmetic reference model, latency and busy-window checks included.
module tb_hypot_unit_param;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a_s;
  logic [W-1:0]   b_s;
  logic [1:0]     mode_s;
  logic [2*W:0]   y;
  logic           busy;
  logic           done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hypot_unit_param #(.W(W)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .a_bi   (a_s),
    .b_bi   (b_s),
    .mode_i (mode_s),
    .start_i(start),
    .y_bo   (y),
    .busy_o (busy),
    .done_o (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] isqrt(input logic [63:0] n);
    logic [63:0] r;
    r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  function automatic logic [63:0] model(input logic [1:0] m, input logic [63:0] a,
                                        input logic [63:0] b);
    case (m)
      2'd0:    return isqrt(a * a + b * b);
      2'd1:    return a * a + b * b;
      2'd2:    return isqrt(a);
      default: return a * b;
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] m);
    case (m)
      2'd0:    return 3 * W + 2;
      2'd1:    return 2 * W + 1;
      2'd2:    return W + 1;
      default: return W;
    endcase
  endfunction

  // Issue one operation, scramble the inputs while it runs, wait for done,
  // and check result, latency and the busy window against the model.
  task automatic run(input string tag, input logic [1:0] m, input logic [W-1:0] a,
                     input logic [W-1:0] b, input int poke, output logic [63:0] yv);
    int lat;
    int busy_n;
    mode_s = m;
    a_s    = a;
    b_s    = b;
    start  = 1'b1;
    step();
    start  = 1'b0;
    mode_s = 2'($urandom);
    a_s    = W'($urandom);
    b_s    = W'($urandom);
    lat    = 0;
    busy_n = 0;
    while (lat < 200) begin
      if (busy) busy_n++;
      if (poke != 0 && lat == poke) begin
        start = 1'b1;
        a_s   = W'(9);
      end else begin
        start = 1'b0;
      end
      step();
      lat++;
      if (done) break;
    end
    start = 1'b0;
    yv = 64'(y);
    $display("op %s mode=%0d a=%0d b=%0d y=%0d lat=%0d busy=%0d", tag, m, a, b, yv, lat, busy_n);
    check({tag, "_y"}, yv, model(m, 64'(a), 64'(b)));
    check({tag, "_lat"}, 64'(lat), 64'(lat_of(m)));
    check({tag, "_busy"}, 64'(busy_n), 64'(lat_of(m)));
  endtask

  initial begin
    logic [63:0] yv;
    logic [1:0]  rm;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int done_seen;

    rst    = 1'b1;
    start  = 1'b0;
    a_s    = '0;
    b_s    = '0;
    mode_s = '0;
    step();
    step();
    check("rst_y", 64'(y), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    step();

    run("hyp_3_4", 2'd0, 8'd3, 8'd4, 0, yv);
    check("hyp_3_4_const", yv, 64'd5);
    step();
    check("done_pulse_width", 64'(done), 64'd0);

    run("hyp_255", 2'd0, 8'd255, 8'd255, 0, yv);
    check("hyp_255_const", yv, 64'd360);
    run("sumsq_255", 2'd1, 8'd255, 8'd255, 0, yv);
    check("sumsq_255_const", yv, 64'd130050);

    run("sqrt_200", 2'd2, 8'd200, 8'd77, 0, yv);
    check("sqrt_200_const", yv, 64'd14);
    step();
    step();
    step();
    check("y_hold", 64'(y), 64'd14);
    run("mul_255", 2'd3, 8'd255, 8'd255, 0, yv);
    check("mul_255_const", yv, 64'd65025);

    run("hyp_0_poke", 2'd0, 8'd0, 8'd0, 5, yv);
    check("hyp_0_const", yv, 64'd0);

    run("mul_7_9", 2'd3, 8'd7, 8'd9, 0, yv);
    check("b2b_in_done", 64'(done), 64'd1);
    run("mul_2_3_b2b", 2'd3, 8'd2, 8'd3, 0, yv);
    check("mul_2_3_const", yv, 64'd6);

    // Abort a HYPOT operation partway through with reset.
    mode_s = 2'd0;
    a_s    = 8'd3;
    b_s    = 8'd4;
    start  = 1'b1;
    step();
    start = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 19; i++) begin
      step();
      if (done) done_seen++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_y", 64'(y), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    $display("op abort_hypot done_seen=%0d", done_seen);

    rst    = 1'b1;
    start  = 1'b1;
    mode_s = 2'd3;
    a_s    = 8'd5;
    b_s    = 8'd5;
    step();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_busy", 64'(busy), 64'd0);
    step();
    check("rst_start_busy2", 64'(busy), 64'd0);
    check("rst_start_y", 64'(y), 64'd0);
    $display("op reset_with_start busy=%0d y=%0d", busy, y);

    for (int i = 0; i < 24; i++) begin
      rm = 2'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? W'(255) : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom);
      run("rand", rm, ra, rb, 0, yv);
      if (i % 3 != 0) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
